// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if
//   Bundles the multiply request/response signals and the borrowed-ALU drive
//   and return signals of alu_mul_seq.
//   Request:  start, a, b              (requester -> sequencer)
//   Response: busy, done, product      (sequencer -> requester)
//   ALU:      alu_A, alu_B, alu_control (sequencer -> ALU), alu_out (ALU -> sequencer)
//   slave modport is the sequencer's view; master modport is the surrounding
//   system (requester plus ALU).
interface alu_mul_seq_if;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [63:0] product;
   logic [31:0] alu_A;
   logic [31:0] alu_B;
   logic [2:0]  alu_control;
   logic [31:0] alu_out;

   modport master (
      output start, a, b, alu_out,
      input  busy, done, product, alu_A, alu_B, alu_control
   );

   modport slave (
      input  start, a, b, alu_out,
      output busy, done, product, alu_A, alu_B, alu_control
   );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq
//   Unsigned 32x32->64 shift-add multiplier. It borrows the external 32-bit
//   ALU as its only adder, issuing one add per cycle for 32 cycles.
//   Ports:
//     clock - rising-edge clock
//     reset - asynchronous active-high reset, clears every register
//     bus   - alu_mul_seq_if.slave: start/a/b request, busy/done/product
//             response, alu_A/alu_B/alu_control drive and alu_out return
//   Timing: accept on edge E0, 32 RUN cycles, 1 DONE cycle (done pulse and
//   product update), then IDLE. product holds until the next completion.
module alu_mul_seq (
   input  logic         clock,
   input  logic         reset,
   alu_mul_seq_if.slave bus
);

   localparam logic [2:0] ALU_ADD = 3'b010;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [5:0]  count_q, count_d;
   logic [63:0] product_q, product_d;

   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] sum;
   logic        carry;

   // ALU drive depends only on registered state. It is kept apart from the
   // next-state logic so the external ALU loop does not pass through one
   // process.
   always_comb begin : alu_drive
      alu_a = '0;
      alu_b = '0;
      if (state_q == RUN) begin
         alu_a = hi_q;
         alu_b = lo_q[0] ? mcand_q : '0;
      end
   end

   assign bus.alu_A       = alu_a;
   assign bus.alu_B       = alu_b;
   assign bus.alu_control = ALU_ADD;

   assign sum = bus.alu_out;
   // The ALU gives no carry-out. For unsigned addition, bit 32 is set when
   // both MSBs are set, or when one MSB is set and the result MSB is clear.
   assign carry = (alu_a[31] & alu_b[31]) | ((alu_a[31] | alu_b[31]) & ~sum[31]);

   always_comb begin : next_state
      state_d   = state_q;
      mcand_d   = mcand_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      count_d   = count_q;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               mcand_d = bus.a;
               hi_d    = '0;
               lo_d    = bus.b;
               count_d = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // {carry, sum, lo} forms a 65-bit partial product, shifted right by one.
            {hi_d, lo_d} = {carry, sum, lo_q[31:1]};
            count_d      = count_q + 6'd1;
            if (count_q == 6'd31) begin
               product_d = {carry, sum, lo_q[31:1]};
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = (state_q == DONE);
   assign bus.product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq
//   Bench for alu_mul_seq. A behavioural 32-bit ALU closes the combinational
//   loop. Expected products come from plain 64-bit multiplication.
module tb_alu_mul_seq;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   alu_mul_seq_if bus ();

   alu_mul_seq dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Datapath ALU: add for 3'b010. Any other code returns a difference, so a
   // wrong op select corrupts the product.
   assign bus.alu_out = (bus.alu_control == 3'b010) ? (bus.alu_A + bus.alu_B)
                                                     : (bus.alu_A - bus.alu_B);

   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      logic [63:0] wx, wy;
      wx = {32'd0, x};
      wy = {32'd0, y};
      return wx * wy;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Must be called at a negedge while the DUT is idle. The task returns at
   // the negedge of cycle 34 after acceptance, which is the first IDLE cycle.
   // With disturb set, start stays high and a/b change randomly through RUN and DONE.
   task automatic do_mul(input logic [31:0] op_a, input logic [31:0] op_b, input bit disturb,
                         output int lat, output int busy_cyc, output int dones,
                         output int bad_ctl, output logic [63:0] prod, output logic busy_after);
      bus.start = 1'b1;
      bus.a     = op_a;
      bus.b     = op_b;
      lat = 0; busy_cyc = 0; dones = 0; bad_ctl = 0;
      prod = '0; busy_after = 1'b1;
      for (int cyc = 1; cyc <= 34; cyc++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) busy_cyc++;
         if (bus.done === 1'b1) begin
            dones++;
            if (lat == 0) lat = cyc;
            prod = bus.product;
         end
         if (bus.alu_control !== 3'b010) bad_ctl++;
         if (cyc == 34) busy_after = bus.busy;
         if (disturb && cyc <= 33) begin
            bus.start = 1'b1;
            bus.a     = $urandom();
            bus.b     = $urandom();
         end else begin
            bus.start = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0; bus.a = '0; bus.b = '0;
      repeat (3) @(negedge clk);
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.done); end
      vectors++; if (bus.product !== 64'd0) begin miscompares++; $display("FAIL reset_product: got %h want 0", bus.product); end
      vectors++; if (bus.alu_A !== 32'd0 || bus.alu_B !== 32'd0) begin miscompares++; $display("FAIL reset_alu_ops: got A=%h B=%h want 0/0", bus.alu_A, bus.alu_B); end
      vectors++; if (bus.alu_control !== 3'b010) begin miscompares++; $display("FAIL reset_alu_ctl: got %b want 010", bus.alu_control); end
      rst = 1'b0;
      @(negedge clk);
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_small();
      int lat, bc, dn, bad; logic [63:0] p; logic ba;
      do_mul(32'd3, 32'd5, 1'b0, lat, bc, dn, bad, p, ba);
      vectors++; if (lat != 33) begin miscompares++; $display("FAIL small_latency: got %0d want 33", lat); end
      vectors++; if (p !== 64'h0000_0000_0000_000F) begin miscompares++; $display("FAIL small_product: got %h want 000000000000000f", p); end
      vectors++; if (bc != 33) begin miscompares++; $display("FAIL small_busy_cycles: got %0d want 33", bc); end
      vectors++; if (dn != 1) begin miscompares++; $display("FAIL small_done_pulses: got %0d want 1", dn); end
      vectors++; if (bad != 0) begin miscompares++; $display("FAIL small_alu_ctl: got %0d bad cycles want 0", bad); end
      vectors++; if (ba !== 1'b0) begin miscompares++; $display("FAIL small_busy_after: got %b want 0", ba); end
      repeat (3) @(negedge clk);
      vectors++; if (bus.product !== 64'hF) begin miscompares++; $display("FAIL small_product_hold: got %h want f", bus.product); end
   endtask

   task automatic test_corners();
      logic [31:0] ta [4];
      logic [31:0] tb [4];
      logic [63:0] te [4];
      int lat, bc, dn, bad; logic [63:0] p; logic ba;
      ta[0] = 32'hFFFF_FFFF; tb[0] = 32'hFFFF_FFFF; te[0] = 64'hFFFF_FFFE_0000_0001;
      ta[1] = 32'h8000_0000; tb[1] = 32'd2;         te[1] = 64'h0000_0001_0000_0000;
      ta[2] = 32'd0;         tb[2] = 32'h1234_5678; te[2] = 64'd0;
      ta[3] = 32'h8000_0000; tb[3] = 32'h8000_0000; te[3] = 64'h4000_0000_0000_0000;
      for (int i = 0; i < 4; i++) begin
         do_mul(ta[i], tb[i], 1'b0, lat, bc, dn, bad, p, ba);
         vectors++; if (p !== te[i]) begin miscompares++; $display("FAIL corner_%0d_product: got %h want %h", i, p, te[i]); end
         vectors++; if (lat != 33 || dn != 1 || bad != 0) begin miscompares++; $display("FAIL corner_%0d_timing: got lat=%0d dones=%0d badctl=%0d want 33/1/0", i, lat, dn, bad); end
      end
   endtask

   task automatic test_random();
      int lat, bc, dn, bad; logic [63:0] p; logic ba;
      logic [31:0] x, y;
      for (int i = 0; i < 16; i++) begin
         x = $urandom();
         y = $urandom();
         if (i % 4 == 1) x = x | 32'h8000_0000;
         if (i % 4 == 2) y = y | 32'hC000_0001;
         do_mul(x, y, 1'b0, lat, bc, dn, bad, p, ba);
         vectors++; if (p !== ref_mul(x, y)) begin miscompares++; $display("FAIL random_%0d_product: a=%h b=%h got %h want %h", i, x, y, p, ref_mul(x, y)); end
         vectors++; if (lat != 33 || bad != 0) begin miscompares++; $display("FAIL random_%0d_timing: got lat=%0d badctl=%0d want 33/0", i, lat, bad); end
      end
   endtask

   task automatic test_isolation();
      int lat, bc, dn, bad; logic [63:0] p; logic ba;
      logic [31:0] x, y;
      do_mul(32'd7, 32'd6, 1'b1, lat, bc, dn, bad, p, ba);
      vectors++; if (p !== 64'd42) begin miscompares++; $display("FAIL iso_product: got %h want 2a", p); end
      vectors++; if (dn != 1) begin miscompares++; $display("FAIL iso_done_pulses: got %0d want 1", dn); end
      vectors++; if (lat != 33 || bc != 33) begin miscompares++; $display("FAIL iso_timing: got lat=%0d busy=%0d want 33/33", lat, bc); end
      vectors++; if (ba !== 1'b0) begin miscompares++; $display("FAIL iso_start_in_done: got busy=%b want 0", ba); end
      // Back-to-back: start in the first IDLE cycle must be accepted.
      x = $urandom(); y = $urandom();
      do_mul(x, y, 1'b0, lat, bc, dn, bad, p, ba);
      vectors++; if (lat != 33) begin miscompares++; $display("FAIL b2b_latency: got %0d want 33", lat); end
      vectors++; if (p !== ref_mul(x, y)) begin miscompares++; $display("FAIL b2b_product: got %h want %h", p, ref_mul(x, y)); end
   endtask

   task automatic test_reset_mid();
      int lat, bc, dn, bad; logic [63:0] p; logic ba;
      bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before: got %b want 1", bus.busy); end
      rst = 1'b1;
      #1;
      vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL mid_reset_flags: got busy=%b done=%b want 0/0", bus.busy, bus.done); end
      vectors++; if (bus.product !== 64'd0) begin miscompares++; $display("FAIL mid_reset_product: got %h want 0", bus.product); end
      vectors++; if (bus.alu_A !== 32'd0 || bus.alu_B !== 32'd0 || bus.alu_control !== 3'b010) begin miscompares++; $display("FAIL mid_reset_alu: got A=%h B=%h ctl=%b want 0/0/010", bus.alu_A, bus.alu_B, bus.alu_control); end
      @(negedge clk);
      rst = 1'b0;
      do_mul(32'd2, 32'd3, 1'b0, lat, bc, dn, bad, p, ba);
      vectors++; if (p !== 64'd6) begin miscompares++; $display("FAIL mid_after_product: got %h want 6", p); end
      vectors++; if (lat != 33 || dn != 1) begin miscompares++; $display("FAIL mid_after_timing: got lat=%0d dones=%0d want 33/1", lat, dn); end
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      test_reset();
      test_small();
      test_corners();
      test_random();
      test_isolation();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
